// File: rtl/adc_capture_controller.sv
// -----------------------------------------------------------------------------
// adc_capture_controller
//   Receive side of the RFDC data path. An armed command starts a capture at an
//   exact RTIO counter value. Each ADC beat carries 16 signed 16-bit samples.
//   The samples are summed over windows of N counted beats, and one timestamped
//   record per window is pushed into the RTI FIFO write port.
//
// Ports
//   s00_axis_aclk / s00_axis_aresetn : clock, async active-low reset
//   s00_axis_tdata/tvalid/tready     : ADC stream in (tready is never dropped)
//   counter                          : RTIO time counter (same clock)
//   cmd_write / cmd_din              : command strobe,
//                                      {abort, window_beats, num_windows, start_time}
//   flush                            : sync abort of the capture + clear of sticky errors
//   rti_full / rti_write / rti_din   : FIFO write port,
//                                      record = {timestamp, sum[47:0], window index}
//   busy                             : capture active or records still in flight
//   timestamp_error, overflow_error  : sticky error flags
// -----------------------------------------------------------------------------
module adc_capture_controller #(
   parameter int AXIS_DATA_WIDTH = 256,
   parameter int SAMPLE_WIDTH    = 16,
   parameter int SUM_WIDTH       = 48
) (
   input  logic                       s00_axis_aclk,
   input  logic                       s00_axis_aresetn,
   input  logic [AXIS_DATA_WIDTH-1:0] s00_axis_tdata,
   input  logic                       s00_axis_tvalid,
   output logic                       s00_axis_tready,
   input  logic [63:0]                counter,
   input  logic                       cmd_write,
   input  logic [127:0]               cmd_din,
   input  logic                       flush,
   input  logic                       rti_full,
   output logic                       rti_write,
   output logic [127:0]               rti_din,
   output logic                       busy,
   output logic                       timestamp_error,
   output logic                       overflow_error
);

   localparam int NUM_LANES = AXIS_DATA_WIDTH / SAMPLE_WIDTH;
   localparam int BSUM_W    = SAMPLE_WIDTH + $clog2(NUM_LANES);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_CAPT  = 2'd2;

   logic [1:0]  r_state;
   logic [63:0] r_start;
   logic [15:0] r_nwin, r_wbeats, r_beat_cnt, r_win_idx;
   logic [63:0] r_win_ts;
   logic        r_tready;

   // beat stage
   logic                     r_b_vld, r_b_first, r_b_last;
   logic signed [BSUM_W-1:0] r_b_sum;
   logic [63:0]              r_b_ts;
   logic [15:0]              r_b_idx;
   // accumulate stage
   logic                 r_r_vld, r_o_vld;
   logic [SUM_WIDTH-1:0] r_acc;
   logic [63:0]          r_r_ts;
   logic [15:0]          r_r_idx;

   logic                     r_write, r_ts_err, r_ovf;
   logic [127:0]             r_din;
   logic signed [BSUM_W-1:0] w_bsum;
   logic w_abort, w_kill, w_match, w_active, w_beat, w_first, w_wlast, w_final;
   logic w_late, w_cmd_ok;
   logic w_unused;

   assign w_unused = ^cmd_din[127:97];

   // Sign-extended sum of all lanes of the current beat.
   always_comb begin
      logic [SAMPLE_WIDTH-1:0] w_lane;
      w_bsum = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         w_lane = s00_axis_tdata[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
         w_bsum = w_bsum + {{(BSUM_W-SAMPLE_WIDTH){w_lane[SAMPLE_WIDTH-1]}}, w_lane};
      end
   end

   assign w_abort  = cmd_write & cmd_din[96];
   assign w_kill   = flush | w_abort;
   assign w_match  = (counter == r_start);
   // The match cycle itself already counts as a capture beat.
   assign w_active = (r_state == ST_CAPT) | ((r_state == ST_ARMED) & w_match);
   assign w_beat   = w_active & s00_axis_tvalid & ~w_kill;
   assign w_first  = (r_beat_cnt == 16'd0);
   assign w_wlast  = (r_beat_cnt == r_wbeats - 16'd1);
   assign w_final  = w_wlast & (r_win_idx == r_nwin - 16'd1);
   assign w_late   = (cmd_din[63:0] < counter);
   assign w_cmd_ok = ~cmd_din[96] & ~w_late & (cmd_din[79:64] != 16'd0);

   // Control FSM and window/beat counters
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         r_state    <= ST_IDLE;
         r_start    <= '0;
         r_nwin     <= '0;
         r_wbeats   <= '0;
         r_beat_cnt <= '0;
         r_win_idx  <= '0;
         r_win_ts   <= '0;
         r_tready   <= 1'b0;
      end else begin
         r_tready <= 1'b1;
         if (w_kill) begin
            r_state <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (cmd_write && w_cmd_ok) begin
                     r_start    <= cmd_din[63:0];
                     r_nwin     <= cmd_din[79:64];
                     r_wbeats   <= (cmd_din[95:80] == 16'd0) ? 16'd1 : cmd_din[95:80];
                     r_beat_cnt <= '0;
                     r_win_idx  <= '0;
                     // A start time equal to "now" can no longer be matched,
                     // so capture begins on the very next cycle instead.
                     r_state    <= (cmd_din[63:0] == counter) ? ST_CAPT : ST_ARMED;
                  end
               end
               default: begin
                  if (w_beat) begin
                     if (w_first) r_win_ts <= counter;
                     if (w_wlast) begin
                        r_beat_cnt <= '0;
                        if (w_final) begin
                           r_state <= ST_IDLE;
                        end else begin
                           r_win_idx <= r_win_idx + 16'd1;
                           r_state   <= ST_CAPT;
                        end
                     end else begin
                        r_beat_cnt <= r_beat_cnt + 16'd1;
                        r_state    <= ST_CAPT;
                     end
                  end else if (w_active) begin
                     r_state <= ST_CAPT;
                  end
               end
            endcase
         end
      end
   end

   // Beat -> accumulate -> record pipeline
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         r_b_vld   <= 1'b0;
         r_b_first <= 1'b0;
         r_b_last  <= 1'b0;
         r_b_sum   <= '0;
         r_b_ts    <= '0;
         r_b_idx   <= '0;
         r_r_vld   <= 1'b0;
         r_o_vld   <= 1'b0;
         r_acc     <= '0;
         r_r_ts    <= '0;
         r_r_idx   <= '0;
         r_write   <= 1'b0;
         r_din     <= '0;
      end else begin
         r_b_vld <= w_beat;
         if (w_beat) begin
            r_b_first <= w_first;
            r_b_last  <= w_wlast;
            r_b_sum   <= w_bsum;
            r_b_ts    <= w_first ? counter : r_win_ts;
            r_b_idx   <= r_win_idx;
         end
         // A kill drops anything not yet in the output register.
         r_r_vld <= r_b_vld & r_b_last & ~w_kill;
         if (r_b_vld) begin
            // The first beat restarts the sum, so no separate clear cycle is needed
            // between back-to-back windows.
            r_acc   <= (r_b_first ? '0 : r_acc) +
                       {{(SUM_WIDTH-BSUM_W){r_b_sum[BSUM_W-1]}}, r_b_sum};
            r_r_ts  <= r_b_ts;
            r_r_idx <= r_b_idx;
         end
         r_o_vld <= r_r_vld;
         r_write <= r_r_vld & ~rti_full;
         if (r_r_vld && !rti_full) r_din <= {r_r_ts, r_acc, r_r_idx};
      end
   end

   // Sticky errors; flush clears and takes priority.
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         r_ts_err <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (flush) begin
         r_ts_err <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && cmd_write && !cmd_din[96] && w_late) r_ts_err <= 1'b1;
         if (r_r_vld && rti_full) r_ovf <= 1'b1;
      end
   end

   assign s00_axis_tready = r_tready;
   assign rti_write       = r_write;
   assign rti_din         = r_din;
   // r_o_vld keeps busy up for the cycle in which the last record is written or dropped.
   assign busy            = (r_state != ST_IDLE) | r_b_vld | r_r_vld | r_o_vld;
   assign timestamp_error = r_ts_err;
   assign overflow_error  = r_ovf;

endmodule

// File: tb/tb_adc_capture_controller.sv
module tb_adc_capture_controller;

   logic         clk = 1'b0, rst_n = 1'b0;
   logic [255:0] tdata = '0;
   logic         tvalid = 1'b0, tready;
   logic [63:0]  counter = '0;
   logic         cmd_write = 1'b0;
   logic [127:0] cmd_din = '0;
   logic         flush = 1'b0, rti_full = 1'b0;
   logic         rti_write, busy, ts_err, ovf;
   logic [127:0] rti_din;

   always #5 clk = ~clk;

   adc_capture_controller dut (
      .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .s00_axis_tdata(tdata),
      .s00_axis_tvalid(tvalid), .s00_axis_tready(tready), .counter(counter),
      .cmd_write(cmd_write), .cmd_din(cmd_din), .flush(flush), .rti_full(rti_full),
      .rti_write(rti_write), .rti_din(rti_din), .busy(busy),
      .timestamp_error(ts_err), .overflow_error(ovf));

   typedef struct {
      logic [63:0] ts;
      logic [47:0] sum;
      logic [15:0] idx;
      int          cyc;
   } rec_t;

   typedef struct {
      int ctr0; int start; int nw; int wb; int mode; int sval; bit alt; int full_idx;
      bit exp_ts_err; bit exp_ovf; int exp_writes;
   } vec_t;

   rec_t sb[$];
   int checks = 0, failures = 0, cyc = 0, iter = 0, nwrites = 0;
   int full_at = -1, cur_full_idx = -1;
   logic [63:0] ctr = '0;

   // reference model state
   int                 m_state = 0, m_cnt = 0, m_idx = 0, m_nw = 0, m_wb = 1;
   logic [63:0]        m_start = '0, m_ts = '0;
   logic signed [47:0] m_sum = '0;
   bit                 m_ts_err = 0, m_ovf = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   // Scoreboard: compare each FIFO write against the oldest expected record.
   always @(negedge clk) begin
      if (rst_n && rti_write) begin
         nwrites++;
         if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_write din=%h", rti_din);
         end else begin
            rec_t r;
            r = sb.pop_front();
            chk("rec_ts",  rti_din[127:64], r.ts);
            chk("rec_sum", {16'd0, rti_din[63:16]}, {16'd0, r.sum});
            chk("rec_idx", {48'd0, rti_din[15:0]}, {48'd0, r.idx});
            chk("rec_cycle", 64'(cyc), 64'(r.cyc));
         end
      end
   end

   function automatic logic [127:0] mk(input logic [63:0] st, input int nw, input int wb,
                                        input bit ab);
      logic [15:0] n, w;
      n = 16'(nw);
      w = 16'(wb);
      return {31'd0, ab, w, n, st};
   endfunction

   task automatic mreset(input int p);
      m_state = 0;
      m_cnt = 0;
      for (int j = sb.size() - 1; j >= 0; j--)
         if (sb[j].cyc > p) sb.delete(j);
   endtask

   // Drive one clock cycle of stimulus and advance the model in step.
   task automatic tick(input bit cw, input logic [127:0] cd, input bit fl, input bit tv,
                       input int mode, input int sval);
      logic signed [47:0] bs;
      logic [15:0]        lane;
      int                 p;
      p = cyc + 1;
      bs = '0;
      for (int i = 0; i < 16; i++) begin
         lane = (mode == 1) ? 16'($urandom) : 16'(sval);
         tdata[i*16 +: 16] = lane;
         bs = bs + {{32{lane[15]}}, lane};
      end
      counter = ctr; tvalid = tv; cmd_write = cw; cmd_din = cd; flush = fl;
      rti_full = (iter == full_at);
      if (fl) begin
         mreset(p); m_ts_err = 0; m_ovf = 0;
      end else if (cw && cd[96]) begin
         mreset(p);
      end else if (m_state != 0 && tv && (m_state == 2 || ctr == m_start)) begin
         if (m_cnt == 0) begin m_ts = ctr; m_sum = '0; end
         m_sum = m_sum + bs;
         m_cnt++;
         m_state = 2;
         if (m_cnt == m_wb) begin
            if (m_idx == cur_full_idx) begin
               full_at = iter + 2; m_ovf = 1;
            end else begin
               sb.push_back('{m_ts, m_sum, 16'(m_idx), p + 2});
            end
            m_cnt = 0;
            m_idx++;
            if (m_idx == m_nw) m_state = 0;
         end
      end else if (m_state == 1 && ctr == m_start) begin
         m_state = 2;
      end else if (m_state == 0 && cw) begin
         if (cd[63:0] < ctr) m_ts_err = 1;
         else if (cd[79:64] != 0) begin
            m_start = cd[63:0]; m_nw = int'(cd[79:64]);
            m_wb = (cd[95:80] == 0) ? 1 : int'(cd[95:80]);
            m_cnt = 0; m_idx = 0;
            m_state = (cd[63:0] == ctr) ? 2 : 1;
         end
      end
      @(posedge clk); #1;
      ctr++; iter++;
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int n, w0;
      bit tv;
      logic [63:0] st;
      tick(0, '0, 1, 0, 0, 0);                       // flush: clean start
      cur_full_idx = v.full_idx;
      w0 = nwrites;
      ctr = 64'(v.ctr0);
      st = 64'(v.start);
      tick(1, mk(st, v.nw, v.wb, 0), 0, 1, v.mode, v.sval);
      chk({nm, "_busy_armed"}, 64'(busy), 64'(v.nw != 0 && !v.exp_ts_err));
      n = ((v.start > v.ctr0) ? v.start - v.ctr0 : 0)
          + v.nw * ((v.wb == 0) ? 1 : v.wb) * (v.alt ? 2 : 1) + 12;
      for (int i = 0; i < n; i++) begin
         tv = v.alt ? !(ctr[0] ^ st[0]) : 1'b1;
         tick(0, '0, 0, tv, v.mode, v.sval);
      end
      chk({nm, "_busy_end"}, 64'(busy), 64'd0);
      chk({nm, "_ts_err"},   64'(ts_err), 64'(v.exp_ts_err));
      chk({nm, "_ovf"},      64'(ovf), 64'(v.exp_ovf));
      chk({nm, "_writes"},   64'(nwrites - w0), 64'(v.exp_writes));
      chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
      cur_full_idx = -1;
   endtask

   task automatic do_async_reset();
      rst_n = 1'b0;
      #2;
      chk("rst_async_busy",  64'(busy), 64'd0);
      chk("rst_async_write", 64'(rti_write), 64'd0);
      chk("rst_async_ready", 64'(tready), 64'd0);
      mreset(-1);
      sb.delete();
      full_at = -1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   vec_t vecs[9];

   initial begin
      //          ctr0 start nw wb    mode sval   alt full ts ovf wr
      vecs[0] = '{90, 100, 2, 4,     0, 1,      0, -1,  0, 0, 2};  // basic, sum 64 each
      vecs[1] = '{90, 100, 2, 4,     0, 1,      0,  0,  0, 1, 1};  // window 0 dropped
      vecs[2] = '{80,  50, 2, 4,     0, 1,      0, -1,  1, 0, 0};  // late start
      vecs[3] = '{90, 100, 1, 4,     0, 1,      1, -1,  0, 0, 1};  // tvalid 1,0,1,0
      vecs[4] = '{90, 100, 3, 5,     1, 0,      0, -1,  0, 0, 3};  // random lanes
      vecs[5] = '{90, 100, 3, 0,     1, 0,      0, -1,  0, 0, 3};  // window_beats 0 -> 1
      vecs[6] = '{90, 100, 0, 4,     0, 1,      0, -1,  0, 0, 0};  // no windows
      vecs[7] = '{95, 100, 2, 3,     0, -7,     1,  1,  0, 1, 1};  // last window dropped
      vecs[8] = '{90, 100, 1, 65535, 0, -32768, 0, -1,  0, 0, 1};  // most negative sum

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_ready", 64'(tready), 64'd0);
      chk("rst_write", 64'(rti_write), 64'd0);
      chk("rst_din_hi", rti_din[127:64], 64'd0);
      chk("rst_din_lo", rti_din[63:0], 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_errs", {62'd0, ts_err, ovf}, 64'd0);
      rst_n = 1'b1;
      #1;
      chk("ready_before_edge", 64'(tready), 64'd0);
      @(posedge clk); #1;
      chk("ready_after_edge", 64'(tready), 64'd1);

      for (int k = 0; k < 9; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

      // late command, then flush clears the sticky error
      run_vec(vecs[2], "late_again");
      tick(0, '0, 1, 0, 0, 0);
      chk("flush_clears_ts_err", 64'(ts_err), 64'd0);

      // abort mid-window: nothing written, back to idle, then a normal capture
      begin
         int w0;
         tick(0, '0, 1, 0, 0, 0);
         w0 = nwrites;
         ctr = 64'd90;
         tick(1, mk(64'd100, 2, 4, 0), 0, 1, 0, 1);
         while (ctr < 64'd102) tick(0, '0, 0, 1, 0, 1);
         tick(1, mk(64'd0, 0, 0, 1), 0, 1, 0, 1);
         repeat (6) tick(0, '0, 0, 1, 0, 1);
         chk("abort_busy", 64'(busy), 64'd0);
         chk("abort_writes", 64'(nwrites - w0), 64'd0);
      end
      run_vec(vecs[0], "after_abort");

      // async reset mid-window
      begin
         int w0;
         w0 = nwrites;
         ctr = 64'd90;
         tick(1, mk(64'd100, 2, 4, 0), 0, 1, 0, 1);
         while (ctr < 64'd102) tick(0, '0, 0, 1, 0, 1);
         do_async_reset();
         repeat (6) tick(0, '0, 0, 1, 0, 1);
         chk("reset_busy", 64'(busy), 64'd0);
         chk("reset_writes", 64'(nwrites - w0), 64'd0);
         chk("reset_ready", 64'(tready), 64'd1);
      end
      run_vec(vecs[0], "after_reset");

      // command and flush in the same cycle: flush wins
      ctr = 64'd90;
      tick(1, mk(64'd100, 2, 4, 0), 1, 1, 0, 1);
      chk("cmd_flush_busy", 64'(busy), 64'd0);
      repeat (16) tick(0, '0, 0, 1, 0, 1);
      chk("cmd_flush_idle", 64'(busy), 64'd0);
      chk("cmd_flush_sb", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
